// File: rtl/gnn_result_collector.sv
// Collects the eight GNN results on their ready-flag rising edges, then streams them in slot order.
// Optional GNN_COLLECT_ARGMAX_EN adds per-node class outputs (out1 > out0) latched on drain entry.
module gnn_result_collector #(
    parameter int DW    = 21,
    parameter int NSLOT = 8,
    localparam int IW   = $clog2(NSLOT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_ready,
    input  logic [NSLOT*DW-1:0]     res_in,
    input  logic [NSLOT-1:0]        rdy_in,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [DW-1:0]    m_data,
    output logic [IW-1:0]           m_idx,
    output logic                    m_last,
    output logic                    done,
    output logic                    busy,
`ifdef GNN_COLLECT_ARGMAX_EN
    output logic [NSLOT/2-1:0]      cls,
    output logic                    cls_valid,
`endif
    output logic                    ovf
);

    // Stream contract: a word transfers on any cycle where m_valid & m_ready are both high;
    // while m_valid is high and m_ready is low, m_data/m_idx/m_last are held unchanged.

    typedef enum logic [1:0] {ST_COLLECT, ST_DRAIN, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NSLOT-1:0]  rdy_q;
    logic [NSLOT-1:0]  captured_q, captured_d;
    logic [NSLOT-1:0]  rise_w, cap_w;
    logic [DW-1:0]     slot_q [NSLOT];
    logic [DW-1:0]     slot_d [NSLOT];
    logic              ovf_q, ovf_d;
`ifdef GNN_COLLECT_ARGMAX_EN
    logic [NSLOT/2-1:0] cls_q, cls_d;
`endif

    assign rise_w = rdy_in & ~rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            idx_q      <= '0;
            rdy_q      <= '0;
            captured_q <= '0;
            ovf_q      <= 1'b0;
            for (int k = 0; k < NSLOT; k++) slot_q[k] <= '0;
`ifdef GNN_COLLECT_ARGMAX_EN
            cls_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rdy_q      <= rdy_in;
            captured_q <= captured_d;
            ovf_q      <= ovf_d;
            for (int k = 0; k < NSLOT; k++) slot_q[k] <= slot_d[k];
`ifdef GNN_COLLECT_ARGMAX_EN
            cls_q      <= cls_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        captured_d = captured_q;
        ovf_d      = ovf_q;
        cap_w      = '0;
        case (state_q)
            ST_COLLECT: begin
                // A capturing edge wins over a same-cycle in_ready clear for its slot.
                cap_w      = rise_w & ~captured_q;
                captured_d = (in_ready ? '0 : captured_q) | cap_w;
                if (&captured_d) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (|rise_w) ovf_d = 1'b1;
                if (m_ready) begin
                    if (idx_q == IW'(NSLOT - 1)) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_DONE: begin
                cap_w      = rise_w;
                captured_d = rise_w;
                idx_d      = '0;
                state_d    = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase
        for (int k = 0; k < NSLOT; k++) begin
            slot_d[k] = cap_w[k] ? res_in[k*DW +: DW] : slot_q[k];
        end
    end

`ifdef GNN_COLLECT_ARGMAX_EN
    // Compare against slot_d so the final capture on the entry edge is included.
    always_comb begin
        cls_d = cls_q;
        if (state_q == ST_COLLECT && state_d == ST_DRAIN) begin
            for (int n = 0; n < NSLOT/2; n++) begin
                cls_d[n] = $signed(slot_d[2*n+1]) > $signed(slot_d[2*n]);
            end
        end
    end
`endif

    always_comb begin
        m_valid = (state_q == ST_DRAIN);
        busy    = (state_q == ST_DRAIN);
        done    = (state_q == ST_DONE);
        m_idx   = idx_q;
        m_last  = m_valid && (idx_q == IW'(NSLOT - 1));
        m_data  = m_valid ? slot_q[idx_q] : '0;
        ovf     = ovf_q;
`ifdef GNN_COLLECT_ARGMAX_EN
        cls       = cls_q;
        cls_valid = (state_q == ST_DRAIN) || (state_q == ST_DONE);
`endif
    end

endmodule

// File: tb/tb_gnn_result_collector.sv
// Directed bench for gnn_result_collector: capture, ordered drain, stalls, clear, overflow, reset abort.
module tb_gnn_result_collector;
    localparam int DW    = 21;
    localparam int NSLOT = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_ready;
    logic [NSLOT*DW-1:0]  res_in;
    logic [NSLOT-1:0]     rdy_in;
    logic                 m_valid;
    logic                 m_ready;
    logic [DW-1:0]        m_data;
    logic [2:0]           m_idx;
    logic                 m_last;
    logic                 done;
    logic                 busy;
    logic                 ovf;
`ifdef GNN_COLLECT_ARGMAX_EN
    logic [3:0]           cls;
    logic                 cls_valid;
`endif

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] vals [NSLOT];

    always #5 clk = ~clk;

    gnn_result_collector #(.DW(DW), .NSLOT(NSLOT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_ready (in_ready),
        .res_in   (res_in),
        .rdy_in   (rdy_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_idx    (m_idx),
        .m_last   (m_last),
        .done     (done),
        .busy     (busy),
`ifdef GNN_COLLECT_ARGMAX_EN
        .cls      (cls),
        .cls_valid(cls_valid),
`endif
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vals();
        exp_q.delete();
        for (int k = 0; k < NSLOT; k++) begin
            res_in[k*DW +: DW] = vals[k];
            exp_q.push_back(vals[k]);
        end
    endtask

    // Entered on the first DRAIN cycle; walks all words, optionally stalling at one index.
    task automatic drain(input int stall_at, input int stall_n);
        logic [DW-1:0] e;
        m_ready = 1'b1;
        for (int i = 0; i < NSLOT; i++) begin
            e = exp_q.pop_front();
            if (i == stall_at) begin
                m_ready = 1'b0;
                for (int j = 0; j < stall_n; j++) begin
                    check("stall_valid", 32'(m_valid), 32'(1));
                    check("stall_idx",   32'(m_idx),   32'(i));
                    check("stall_data",  32'(m_data),  32'(e));
                    check("stall_done",  32'(done),    32'(0));
                    step();
                end
                m_ready = 1'b1;
            end
            check("m_valid", 32'(m_valid), 32'(1));
            check("m_idx",   32'(m_idx),   32'(i));
            check("m_data",  32'(m_data),  32'(e));
            check("m_last",  32'(m_last),  32'(i == NSLOT - 1));
            check("busy",    32'(busy),    32'(1));
            step();
        end
        check("done",       32'(done),    32'(1));
        check("done_valid", 32'(m_valid), 32'(0));
        check("done_busy",  32'(busy),    32'(0));
        check("done_idx",   32'(m_idx),   32'(0));
`ifdef GNN_COLLECT_ARGMAX_EN
        check("done_cls_valid", 32'(cls_valid), 32'(1));
`endif
        step();
        check("done_pulse", 32'(done), 32'(0));
`ifdef GNN_COLLECT_ARGMAX_EN
        check("post_cls_valid", 32'(cls_valid), 32'(0));
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        in_ready = 1'b0;
        m_ready  = 1'b0;
        rdy_in   = '0;
        res_in   = '0;
        repeat (3) step();
        check("rst_valid", 32'(m_valid), 32'(0));
        check("rst_busy",  32'(busy),    32'(0));
        check("rst_done",  32'(done),    32'(0));
        check("rst_ovf",   32'(ovf),     32'(0));
        check("rst_idx",   32'(m_idx),   32'(0));
        check("rst_last",  32'(m_last),  32'(0));
        check("rst_data",  32'(m_data),  32'(0));
        rst_n = 1'b1;
        step();

        // All flags rise together; stream starts the next cycle.
        for (int k = 0; k < NSLOT; k++) vals[k] = DW'(k*1000 - 3500);
        load_vals();
        rdy_in = 8'hFF;
        step();
        drain(-1, 0);
        check("t1_ovf", 32'(ovf), 32'(0));
        rdy_in = '0;
        step();

        // Flags rise one per cycle from 7 down to 0, extreme signed values in slots 4/5.
        for (int k = 0; k < NSLOT; k++) vals[k] = DW'(k + 1);
        vals[4] = 21'h0FFFFF;
        vals[5] = 21'h100000;
        load_vals();
        for (int b = NSLOT - 1; b >= 0; b--) begin
            rdy_in[b] = 1'b1;
            step();
            if (b != 0) check("early_drain", 32'(m_valid), 32'(0));
        end
        drain(-1, 0);
        rdy_in = '0;
        step();

        // Backpressure at index 3 for five cycles.
        for (int k = 0; k < NSLOT; k++) vals[k] = DW'(32'h1F0000 + k*17);
        load_vals();
        rdy_in = 8'hFF;
        step();
        drain(3, 5);
        rdy_in = '0;
        step();

        // Partial capture, clear with in_ready, then a full fresh set.
        for (int k = 0; k < NSLOT; k++) vals[k] = DW'(111 * (k + 1));
        load_vals();
        rdy_in = 8'h0F;
        step();
        check("partial_valid", 32'(m_valid), 32'(0));
        rdy_in = '0;
        step();
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        for (int k = 0; k < NSLOT; k++) vals[k] = DW'(-(k*222 + 7));
        load_vals();
        rdy_in = 8'hFF;
        step();
        drain(-1, 0);
        rdy_in = '0;
        step();

`ifdef GNN_COLLECT_ARGMAX_EN
        vals[0] = DW'(5);   vals[1] = DW'(9);
        vals[2] = DW'(9);   vals[3] = DW'(5);
        vals[4] = DW'(-3);  vals[5] = DW'(-3);
        vals[6] = DW'(-10); vals[7] = DW'(-2);
        load_vals();
        check("pre_cls_valid", 32'(cls_valid), 32'(0));
        rdy_in = 8'hFF;
        step();
        check("cls",       32'(cls),       32'(4'b1001));
        check("cls_valid", 32'(cls_valid), 32'(1));
        drain(-1, 0);
        rdy_in = '0;
        step();
`endif

        // Edge on slot 2 during drain flags overflow without touching the stream.
        for (int k = 0; k < NSLOT; k++) vals[k] = DW'(300 + k);
        load_vals();
        rdy_in = 8'hFF;
        step();
        m_ready = 1'b0;
        rdy_in[2] = 1'b0;
        res_in[2*DW +: DW] = 21'h0ABCDE;
        step();
        check("fall_no_ovf", 32'(ovf), 32'(0));
        rdy_in[2] = 1'b1;
        step();
        check("ovf_set",      32'(ovf),   32'(1));
        check("ovf_hold_idx", 32'(m_idx), 32'(0));
        drain(-1, 0);
        check("ovf_sticky", 32'(ovf), 32'(1));
        rdy_in = '0;
        step();

        // Reset in the middle of a drain aborts the stream at once.
        for (int k = 0; k < NSLOT; k++) vals[k] = DW'(50 + k);
        load_vals();
        rdy_in = 8'hFF;
        step();
        m_ready = 1'b1;
        step();
        check("mid_idx", 32'(m_idx), 32'(1));
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(m_valid), 32'(0));
        check("abort_busy",  32'(busy),    32'(0));
        check("abort_ovf",   32'(ovf),     32'(0));
        check("abort_idx",   32'(m_idx),   32'(0));
        rdy_in = '0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 32'(m_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
